// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared pipeline-register types: stage state, EX/MEM control bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } ex_mem_ctrl_t;

  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);

endpackage

`default_nettype wire

// File: rtl/ctrl_pipe_stage.sv
// ============================================================================
// Module : ctrl_pipe_stage
// Brief  : Valid/ready pipeline register with 2-entry skid, flush and bubbles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = EX_MEM_CTRL_W,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_e      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_main, w_main_nxt;
  logic [WIDTH-1:0] r_skid, w_skid_nxt;
  logic             w_in_fire, w_out_fire;

  // Handshake outputs depend on state only, so no comb path crosses the stage.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (r_state)
      ST_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // main is reloaded with BUBBLE whenever the stage empties, so out_data
  // needs no output mux to stay quiet while out_valid is low.
  assign out_data = r_main;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_data;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = BUBBLE;
          w_skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE;
      r_skid  <= BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_stage.sv
// ============================================================================
// Module : tb_ctrl_pipe_stage
// Brief  : Directed table-driven bench for ctrl_pipe_stage (WIDTH=4, BUBBLE=0).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipe_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] occupancy;

  int n_checks;
  int n_errors;

  ctrl_pipe_stage #(.WIDTH(4), .BUBBLE(4'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ov;
    logic [3:0] e_od;
    logic       e_ir;
    logic [1:0] e_occ;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic e_ov, input logic [3:0] e_od,
                       input logic e_ir, input logic [1:0] e_occ);
    n_checks++;
    if (out_valid !== e_ov || out_data !== e_od || in_ready !== e_ir || occupancy !== e_occ) begin
      n_errors++;
      $display("FAIL %s: got ov=%b od=%h ir=%b occ=%0d, want ov=%b od=%h ir=%b occ=%0d",
               name, out_valid, out_data, in_ready, occupancy, e_ov, e_od, e_ir, e_occ);
    end
  endtask

  task automatic add(input logic iv, input logic [3:0] id, input logic ordy, input logic fl,
                     input logic e_ov, input logic [3:0] e_od, input logic e_ir,
                     input logic [1:0] e_occ, input string name);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ; v.name = name;
    vecs.push_back(v);
  endtask

  // Apply one cycle's inputs, clock once, then sample 1 time unit later.
  task automatic step(input logic iv, input logic [3:0] id, input logic ordy, input logic fl);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1; flush = 1'b0;

    // Pass-through: one-cycle latency, no gaps, occupancy 1.
    for (int i = 1; i <= 8; i++)
      add(1, 4'(i), 1, 0, 1, 4'(i), 1, 1, $sformatf("pass_%0d", i));
    add(0, 4'h0, 1, 0, 0, 4'h0, 1, 0, "pass_drain");
    // Backpressure: A, B fill the stage, C held off, then A, B, C in order.
    add(1, 4'hA, 0, 0, 1, 4'hA, 1, 1, "bp_a");
    add(1, 4'hB, 0, 0, 1, 4'hA, 0, 2, "bp_b_full");
    add(1, 4'hC, 0, 0, 1, 4'hA, 0, 2, "bp_c_held");
    add(1, 4'hC, 1, 0, 1, 4'hB, 1, 1, "bp_b_out");
    add(1, 4'hC, 1, 0, 1, 4'hC, 1, 1, "bp_c_out");
    add(0, 4'h0, 1, 0, 0, 4'h0, 1, 0, "bp_drain");
    // Simultaneous in/out fire in ONE.
    add(1, 4'h3, 0, 0, 1, 4'h3, 1, 1, "sim_load3");
    add(1, 4'h5, 1, 0, 1, 4'h5, 1, 1, "sim_swap5");
    add(0, 4'h0, 1, 0, 0, 4'h0, 1, 0, "sim_drain");
    // Flush while FULL with an offered payload.
    add(1, 4'h2, 0, 0, 1, 4'h2, 1, 1, "flf_a");
    add(1, 4'h4, 0, 0, 1, 4'h2, 0, 2, "flf_full");
    add(1, 4'h7, 0, 1, 0, 4'h0, 1, 0, "flf_flush");
    add(0, 4'h0, 1, 0, 0, 4'h0, 1, 0, "flf_after");
    // Flush in ONE discards a same-cycle in_fire.
    add(1, 4'h6, 0, 0, 1, 4'h6, 1, 1, "flo_a");
    add(1, 4'h7, 1, 1, 0, 4'h0, 1, 0, "flo_flush");
    add(0, 4'h0, 1, 0, 0, 4'h0, 1, 0, "flo_after");
    // Stall: out_data frozen for 5 cycles.
    add(1, 4'h9, 0, 0, 1, 4'h9, 1, 1, "stall_load");
    for (int i = 0; i < 5; i++)
      add(0, 4'h0, 0, 0, 1, 4'h9, 1, 1, $sformatf("stall_%0d", i));
    add(0, 4'h0, 1, 0, 0, 4'h0, 1, 0, "stall_drain");

    // Reset held with an offered payload.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 0, 4'h0, 1, 0);
    step(1, 4'hF, 1, 0);
    check("reset_hold_edge", 0, 4'h0, 1, 0);
    rst = 1'b0;
    step(0, 4'h0, 1, 0);
    check("reset_release", 0, 4'h0, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      check(vecs[i].name, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_occ);
    end

    // Asynchronous reset while FULL: outputs clear before the next edge.
    step(1, 4'hD, 0, 0);
    step(1, 4'hE, 0, 0);
    check("arst_full", 1, 4'hD, 0, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_immediate", 0, 4'h0, 1, 0);
    step(1, 4'h1, 1, 0);
    check("arst_held", 0, 4'h0, 1, 0);
    rst = 1'b0;
    step(1, 4'h8, 1, 0);
    check("arst_recover", 1, 4'h8, 1, 1);
    step(0, 4'h0, 1, 0);
    check("arst_drain", 0, 4'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ctrl_pipe_stage.md
# ctrl_pipe_stage

Parametrised pipeline register for control and data bundles between any two pipeline stages (EX/MEM first user), generalising the fixed-field stage registers. It carries a WIDTH-bit payload with a valid/ready handshake, a 2-entry skid buffer so upstream ready is registered, synchronous flush, and bubble insertion. When empty or flushed, the output payload is forced to a bubble value, so downstream write enables are never spuriously asserted.

## Interface
Parameters:
- WIDTH, 4, payload width; EX/MEM default bundle is {reg_write, mem_write, result_src[1:0]}.
- BUBBLE, '0, payload value driven on out_data whenever out_valid is 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage accepts payload; registered, a function of state only.
- in_data  in  WIDTH  upstream payload.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts payload.
- out_data  out  WIDTH  held payload, or BUBBLE when not valid.
- occupancy  out  2  entries held: 0, 1 or 2.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- States:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - ONE: occupancy 1, out_valid 1, in_ready 1.
  - FULL: occupancy 2, out_valid 1, in_ready 0.
- EMPTY: in_fire -> ONE, main <= in_data; otherwise stay.
- ONE:
  - in_fire & out_fire -> ONE, main <= in_data.
  - in_fire & !out_fire -> FULL, skid <= in_data.
  - !in_fire & out_fire -> EMPTY, main <= BUBBLE.
  - neither -> hold.
- FULL: out_fire -> ONE, main <= skid. Otherwise hold; no input is possible because in_ready is 0.
- Ordering: payloads leave in exactly arrival order; none is dropped or duplicated.
- flush has highest priority:
  - Next state is EMPTY; main and skid are loaded with BUBBLE.
  - An in_fire in the same cycle is discarded.
  - in_ready stays at its state-derived value during the flush cycle.
- out_data equals BUBBLE in every cycle that out_valid is 0, including after reset.
- Stall (out_ready held low) freezes out_data and out_valid exactly.

## Timing
- Reset values (asynchronous):
  - state EMPTY, occupancy 0.
  - out_valid 0, in_ready 1.
  - out_data = BUBBLE, skid = BUBBLE.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: in_fire at edge N gives out_valid = 1 with that payload after edge N. Minimum 1 cycle; 2 cycles when the payload passes through skid.
- Throughput: 1 payload/cycle when out_ready is held high.
- in_ready deasserts the cycle after the stage reaches FULL. It reasserts the cycle after the first out_fire from FULL.
- flush at edge N: out_valid = 0 and out_data = BUBBLE after edge N; in_ready = 1 after edge N.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

## Structure
- Shared package pipe_pkg holds:
  - the state enum typedef (EMPTY/ONE/FULL);
  - the packed struct ex_mem_ctrl_t {reg_write, mem_write, result_src[1:0]};
  - the localparam EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t).
- Single module; no sub-module. The skid and main registers are too small to split out.
- Instantiators pack bundles into WIDTH and set BUBBLE so all write enables are 0.

## Test plan
- Reset: hold rst with in_valid = 1, in_data = 4'hF -> out_valid 0, out_data 4'h0, in_ready 1, occupancy 0. Assert rst asynchronously while FULL -> outputs return to reset values before the next edge.
- Pass-through: out_ready = 1, stream 4'h1..4'h8 back-to-back -> 4'h1..4'h8 on out_data with 1-cycle latency, no gaps, occupancy stays 1.
- Backpressure: out_ready = 0, offer 4'hA then 4'hB -> occupancy 2, in_ready 0 after the second edge, 4'hC held off. Raise out_ready -> A, B, C emerge in order.
- Simultaneous fire in ONE: main = 4'h3, in_data = 4'h5, both fires in one cycle -> out_data = 4'h5, occupancy stays 1.
- Flush while FULL with in_valid = 1, in_data = 4'h7 -> after the edge: out_valid 0, out_data BUBBLE, occupancy 0, 4'h7 never appears on out_data.
- Stall hold: out_valid 1 with out_data = 4'h9, out_ready = 0 for 5 cycles -> out_data is stable at 4'h9 for all 5 cycles.
